// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//   - default address / data widths of the 16-bit datapath
//   - read-owner encoding used to route returning read data
//   - last-winner encoding used by the round-robin tie break
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Who owns the read that returns data this cycle
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  // Which requester took the most recent grant
  localparam logic WIN_IF = 1'b0;
  localparam logic WIN_D  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch / data requesters, the arbiter and the
// single-port synchronous memory.
//   if_*  : fetch read request, grant and returned data
//   d_*   : data load/store request, grant and returned load data
//   mem_* : memory command (en/we/addr/wdata) and read data
// Modports:
//   slave  - the arbiter's view (takes requests, drives grants and memory)
//   master - the surrounding system (requesters plus memory)
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter, purely combinational.
//   req[0]   : fetch request      gnt[0] : fetch granted
//   req[1]   : data request       gnt[1] : data granted
//   last_win : requester that won the previous grant (WIN_IF / WIN_D)
// A lone requester always wins; on a tie the side that did not win last
// time is granted, which yields strict alternation under sustained load.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_win,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (last_win == WIN_IF) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// data load/store. One access is granted per cycle, combinationally, in the
// same cycle the request is presented. The owner of the single outstanding
// read is registered so the data returning one cycle later is steered to
// the requester that issued it.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : request / grant / memory bundle (slave view)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
)(
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  logic       last_win;
  logic [1:0] rd_owner, rd_owner_nxt;
  logic [1:0] req, gnt;
  logic       if_rvalid, d_rvalid;

  // Masking the requests during reset is what keeps every grant, and with
  // it every memory command, low while reset is high.
  assign req = reset ? 2'b00 : {bus.d_req, bus.if_req};

  rr_arb2 u_arb (
    .req      (req),
    .last_win (last_win),
    .gnt      (gnt)
  );

  // Next read owner: only a read grant produces returning data. Stores
  // complete with d_gnt alone.
  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (gnt[0]) begin
      rd_owner_nxt = OWN_IF;
    end else if (gnt[1] && !bus.d_we) begin
      rd_owner_nxt = OWN_D;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_win <= WIN_IF;
      rd_owner <= OWN_NONE;
    end else begin
      rd_owner <= rd_owner_nxt;
      if (gnt[1]) begin
        last_win <= WIN_D;
      end else if (gnt[0]) begin
        last_win <= WIN_IF;
      end
    end
  end

  // rd_owner still holds the pre-reset read during the first reset cycle,
  // so rvalid is qualified with reset to discard that read.
  assign if_rvalid = !reset && (rd_owner == OWN_IF);
  assign d_rvalid  = !reset && (rd_owner == OWN_D);

  assign bus.if_gnt    = gnt[0];
  assign bus.d_gnt     = gnt[1];
  assign bus.if_rvalid = if_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.if_rdata  = if_rvalid ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.d_rdata   = d_rvalid  ? bus.mem_rdata : {DATA_W{1'b0}};

  // Memory command mux; everything is zero when nobody is granted.
  // Fetch never writes, so only the data side can raise mem_we.
  assign bus.mem_en    = |gnt;
  assign bus.mem_we    = gnt[1] & bus.d_we;
  assign bus.mem_addr  = gnt[1] ? bus.d_addr  :
                         gnt[0] ? bus.if_addr : {ADDR_W{1'b0}};
  assign bus.mem_wdata = gnt[1] ? bus.d_wdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  typedef struct packed {
    logic [1:0]  own;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] shadow [int];

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Power-up content of the memory model and of the expectation table
  function automatic logic [15:0] init_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'h1234;
    return a * 16'd3 + 16'h0101;
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    if (shadow.exists(int'(a))) return shadow[int'(a)];
    return init_word(a);
  endfunction

  // Synchronous single-port memory model: one-cycle read latency
  logic [15:0] mem_arr [0:1023];
  bit          mem_wr  [0:1023];
  always_ff @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      mem_arr[bus.mem_addr[9:0]] <= bus.mem_wdata;
      mem_wr[bus.mem_addr[9:0]]  <= 1'b1;
    end else if (bus.mem_en) begin
      bus.mem_rdata <= mem_wr[bus.mem_addr[9:0]] ? mem_arr[bus.mem_addr[9:0]]
                                                 : init_word(bus.mem_addr);
    end
  end

  task automatic idle_inputs;
    bus.if_req = 1'b0; bus.if_addr = 16'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 16'h0; bus.d_wdata = 16'h0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0055;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0066; bus.d_wdata = 16'hFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=0000", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata} !== 32'h0) begin
      bad++; $display("FAIL reset_bus got=%h exp=0", {bus.mem_addr, bus.mem_wdata});
    end
    total++;
    if ({bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata} !== 34'h0) begin
      bad++; $display("FAIL reset_rsp got=%h exp=0", {bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    sb.delete();
  endtask

  task automatic test_single_if;
    exp_t e;
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    @(negedge clk);
    total++;
    if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr} !== {4'b1010, 16'h0010}) begin
      bad++; $display("FAIL single_gnt got=%h exp=%h", {bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr}, {4'b1010, 16'h0010});
    end
    sb.push_back('{OWN_IF, exp_word(16'h0010)});
    @(posedge clk); #1;
    bus.if_req = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata} !== {1'b1, e.data, 1'b0, 16'h0}) begin
      bad++; $display("FAIL single_rsp got=%h exp=%h", {bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata}, {1'b1, e.data, 1'b0, 16'h0});
    end
    total++;
    if ({bus.mem_en, bus.mem_addr, bus.mem_wdata} !== 33'h0) begin
      bad++; $display("FAIL idle_bus got=%h exp=0", {bus.mem_en, bus.mem_addr, bus.mem_wdata});
    end
  endtask

  // Tie right after reset: D first, then strict alternation
  task automatic test_tie;
    exp_t e;
    logic exp_d;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    bus.if_req = 1'b1; bus.if_addr = 16'h0004;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = (sb.size() != 0) ? sb.pop_front() : exp_t'{OWN_NONE, 16'h0};
      total++;
      if ({bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata} !==
          {e.own == OWN_IF, e.own == OWN_D, (e.own == OWN_IF) ? e.data : 16'h0, (e.own == OWN_D) ? e.data : 16'h0}) begin
        bad++; $display("FAIL tie_rsp cyc=%0d got=%h exp_own=%0d exp_data=%h", i,
                        {bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.d_rdata}, e.own, e.data);
      end
      exp_d = (i % 2 == 0);
      total++;
      if ({bus.if_gnt, bus.d_gnt, bus.mem_addr} !== {~exp_d, exp_d, exp_d ? 16'h0200 : 16'h0004}) begin
        bad++; $display("FAIL tie_gnt cyc=%0d got=%h exp=%h", i, {bus.if_gnt, bus.d_gnt, bus.mem_addr},
                        {~exp_d, exp_d, exp_d ? 16'h0200 : 16'h0004});
      end
      if (exp_d) sb.push_back('{OWN_D, exp_word(16'h0200)});
      else       sb.push_back('{OWN_IF, exp_word(16'h0004)});
      @(posedge clk); #1;
    end
    idle_inputs();
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({bus.if_rvalid, bus.d_rvalid, bus.if_rdata} !== {2'b10, e.data}) begin
      bad++; $display("FAIL tie_last got=%h exp=%h", {bus.if_rvalid, bus.d_rvalid, bus.if_rdata}, {2'b10, e.data});
    end
  endtask

  task automatic test_write;
    exp_t e;
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0300; bus.d_wdata = 16'hBEEF;
    @(negedge clk);
    total++;
    if ({bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
        {4'b1011, 16'h0300, 16'hBEEF}) begin
      bad++; $display("FAIL wr_cmd got=%h exp=%h", {bus.d_gnt, bus.if_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                      {4'b1011, 16'h0300, 16'hBEEF});
    end
    shadow[32'h0300] = 16'hBEEF;
    @(posedge clk); #1;
    bus.d_we = 1'b0; bus.d_wdata = 16'h0;
    @(negedge clk);
    total++;
    if ({bus.d_rvalid, bus.if_rvalid} !== 2'b00) begin
      bad++; $display("FAIL wr_no_rvalid got=%b exp=00", {bus.d_rvalid, bus.if_rvalid});
    end
    total++;
    if ({bus.d_gnt, bus.mem_we} !== 2'b10) begin
      bad++; $display("FAIL rb_gnt got=%b exp=10", {bus.d_gnt, bus.mem_we});
    end
    sb.push_back('{OWN_D, exp_word(16'h0300)});
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({bus.d_rvalid, bus.d_rdata, bus.if_rvalid} !== {1'b1, e.data, 1'b0}) begin
      bad++; $display("FAIL rb_data got=%h exp=%h", {bus.d_rvalid, bus.d_rdata, bus.if_rvalid}, {1'b1, e.data, 1'b0});
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      if (i < 8) begin
        bus.if_req = 1'b1; bus.if_addr = 16'(i);
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      if (i > 0) begin
        e = (sb.size() != 0) ? sb.pop_front() : exp_t'{OWN_NONE, 16'h0};
        total++;
        if ({bus.if_rvalid, bus.if_rdata, bus.d_rvalid} !== {1'b1, e.data, 1'b0}) begin
          bad++; $display("FAIL b2b_rsp cyc=%0d got=%h exp=%h", i, {bus.if_rvalid, bus.if_rdata, bus.d_rvalid}, {1'b1, e.data, 1'b0});
        end
      end
      if (i < 8) begin
        total++;
        if ({bus.if_gnt, bus.mem_en, bus.mem_addr} !== {2'b11, 16'(i)}) begin
          bad++; $display("FAIL b2b_gnt cyc=%0d got=%h exp=%h", i, {bus.if_gnt, bus.mem_en, bus.mem_addr}, {2'b11, 16'(i)});
        end
        sb.push_back('{OWN_IF, exp_word(16'(i))});
      end
    end
  endtask

  task automatic test_reset_mid_read;
    exp_t e;
    // IF read granted, then reset: its data must never show up
    @(posedge clk); #1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    @(negedge clk);
    total++;
    if (bus.if_gnt !== 1'b1) begin
      bad++; $display("FAIL rst_pre_gnt got=%b exp=1", bus.if_gnt);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0200;
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.if_gnt, bus.d_gnt, bus.mem_en} !== 21'h0) begin
        bad++; $display("FAIL rst_mid cyc=%0d got=%h exp=0", i, {bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.if_gnt, bus.d_gnt, bus.mem_en});
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin
      bad++; $display("FAIL rst_tie1 got=%b exp=01", {bus.if_gnt, bus.d_gnt});
    end
    // D store leaves last_win=D; reset must bring the tie back to D anyway
    @(posedge clk); #1;
    idle_inputs();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0310; bus.d_wdata = 16'h1111;
    @(negedge clk);
    total++;
    if ({bus.d_gnt, bus.mem_we} !== 2'b11) begin
      bad++; $display("FAIL rst_wr got=%b exp=11", {bus.d_gnt, bus.mem_we});
    end
    shadow[32'h0310] = 16'h1111;
    @(posedge clk); #1;
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    bus.if_req = 1'b1; bus.if_addr = 16'h0004;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0310;
    @(negedge clk);
    total++;
    if ({bus.if_gnt, bus.d_gnt, bus.mem_addr} !== {2'b01, 16'h0310}) begin
      bad++; $display("FAIL rst_tie2 got=%h exp=%h", {bus.if_gnt, bus.d_gnt, bus.mem_addr}, {2'b01, 16'h0310});
    end
    sb.push_back('{OWN_D, exp_word(16'h0310)});
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({bus.d_rvalid, bus.d_rdata, bus.if_rvalid} !== {1'b1, e.data, 1'b0}) begin
      bad++; $display("FAIL rst_tie2_rsp got=%h exp=%h", {bus.d_rvalid, bus.d_rdata, bus.if_rvalid}, {1'b1, e.data, 1'b0});
    end
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_single_if();
    test_tie();
    test_write();
    test_back_to_back();
    test_reset_mid_read();
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
